// File: rtl/servo_angle_sequencer.sv
// Frame-synchronous slew controller for a 4-channel servo PWM block.
// Targets arrive over valid/ready; current angles move at most STEP per frame and are presented once per frame with a load strobe.
module servo_angle_sequencer #(
    parameter int FRAME_CYCLES = 1000000,
    parameter int STEP         = 2,
    parameter int MAX_ANGLE    = 180,
    parameter int HOME_ANGLE   = 90
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_chan,
    input  logic [7:0] cmd_angle,
    output logic [7:0] angle1,
    output logic [7:0] angle2,
    output logic [7:0] angle3,
    output logic [7:0] angle4,
    output logic       nextangle,
    output logic [3:0] at_target,
    output logic       frame_tick
);

    localparam int              FC_W    = $clog2(FRAME_CYCLES);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAME_CYCLES - 1);
    localparam logic [7:0]      HOME    = 8'(HOME_ANGLE);
    localparam logic [7:0]      MAXA    = 8'(MAX_ANGLE);
    localparam logic [8:0]      STEP9   = 9'(STEP);
    localparam logic [7:0]      STEP8   = 8'(STEP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UPD0,
        S_UPD1,
        S_UPD2,
        S_UPD3,
        S_LOAD
    } state_t;

    state_t          r_state;
    logic [FC_W-1:0] r_fcnt;
    logic            r_cmd_ready;
    logic            r_nextangle;
    logic            r_frame_tick;
    logic [7:0]      r_angle [4];
    logic [7:0]      r_tgt   [4];
    logic [7:0]      r_cur   [4];

    logic            w_tick;
    logic            w_accept;
    logic [7:0]      w_cmd_angle;
    logic [1:0]      w_upd_ch;
    logic [7:0]      w_slew;
    logic [3:0]      w_at_target;

    function automatic logic [7:0] clamp_angle(input logic [7:0] a);
        return (a > MAXA) ? MAXA : a;
    endfunction

    // Distance is taken at 9 bits so the comparison against STEP never wraps.
    function automatic logic [7:0] slew(input logic [7:0] cur, input logic [7:0] tgt);
        logic [8:0] d;
        if (tgt >= cur) d = {1'b0, tgt} - {1'b0, cur};
        else            d = {1'b0, cur} - {1'b0, tgt};
        if (d <= STEP9)     return tgt;
        else if (tgt > cur) return cur + STEP8;
        else                return cur - STEP8;
    endfunction

    assign w_tick      = (r_fcnt == FC_LAST);
    assign w_accept    = cmd_valid && r_cmd_ready;
    assign w_cmd_angle = clamp_angle(cmd_angle);

    always_comb begin
        w_upd_ch = 2'd0;
        case (r_state)
            S_UPD1:  w_upd_ch = 2'd1;
            S_UPD2:  w_upd_ch = 2'd2;
            S_UPD3:  w_upd_ch = 2'd3;
            default: w_upd_ch = 2'd0;
        endcase
    end

    assign w_slew = slew(r_cur[w_upd_ch], r_tgt[w_upd_ch]);

    always_comb begin
        w_at_target = 4'h0;
        for (int i = 0; i < 4; i++) begin
            w_at_target[i] = (r_cur[i] == r_tgt[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_fcnt       <= '0;
            r_cmd_ready  <= 1'b0;
            r_nextangle  <= 1'b0;
            r_frame_tick <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_angle[i] <= HOME;
                r_tgt[i]   <= HOME;
                r_cur[i]   <= HOME;
            end
        end else begin
            r_fcnt       <= w_tick ? '0 : r_fcnt + 1'b1;
            r_frame_tick <= w_tick;
            r_nextangle  <= 1'b0;
            if (w_accept) begin
                r_tgt[cmd_chan] <= w_cmd_angle;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_tick) begin
                        r_state     <= S_UPD0;
                        r_cmd_ready <= 1'b0;
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                S_UPD0, S_UPD1, S_UPD2: begin
                    r_cur[w_upd_ch] <= w_slew;
                    r_state         <= state_t'(r_state + 3'd1);
                end
                // Channel 3's fresh value is forwarded so all four outputs change on the strobe edge.
                S_UPD3: begin
                    r_cur[3]    <= w_slew;
                    r_angle[0]  <= r_cur[0];
                    r_angle[1]  <= r_cur[1];
                    r_angle[2]  <= r_cur[2];
                    r_angle[3]  <= w_slew;
                    r_nextangle <= 1'b1;
                    r_state     <= S_LOAD;
                end
                S_LOAD: begin
                    r_state     <= S_IDLE;
                    r_cmd_ready <= 1'b1;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_cmd_ready <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready  = r_cmd_ready;
    assign angle1     = r_angle[0];
    assign angle2     = r_angle[1];
    assign angle3     = r_angle[2];
    assign angle4     = r_angle[3];
    assign nextangle  = r_nextangle;
    assign at_target  = w_at_target;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_servo_angle_sequencer.sv
// Directed bench for servo_angle_sequencer with FRAME_CYCLES=20, STEP=2, HOME=90, MAX=180.
module tb_servo_angle_sequencer;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_chan;
    logic [7:0] cmd_angle;
    logic [7:0] angle1, angle2, angle3, angle4;
    logic       nextangle;
    logic [3:0] at_target;
    logic       frame_tick;

    int n_chk  = 0;
    int n_fail = 0;

    servo_angle_sequencer #(
        .FRAME_CYCLES(20),
        .STEP        (2),
        .MAX_ANGLE   (180),
        .HOME_ANGLE  (90)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_chan  (cmd_chan),
        .cmd_angle (cmd_angle),
        .angle1    (angle1),
        .angle2    (angle2),
        .angle3    (angle3),
        .angle4    (angle4),
        .nextangle (nextangle),
        .at_target (at_target),
        .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until the load strobe is seen; n is the number of edges taken.
    task automatic wait_load(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (nextangle !== 1'b1 && n < 64);
        chk("load_seen", {31'd0, nextangle}, 32'd1);
    endtask

    task automatic send(input logic [1:0] ch, input logic [7:0] a);
        cmd_valid = 1'b1;
        cmd_chan  = ch;
        cmd_angle = a;
        step();
        cmd_valid = 1'b0;
    endtask

    initial begin
        int m;
        int zeros;
        int load_idx;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_chan  = 2'd0;
        cmd_angle = 8'd0;

        repeat (3) step();
        chk("rst_angles", {angle1, angle2, angle3, angle4}, {8'd90, 8'd90, 8'd90, 8'd90});
        chk("rst_at_target", {28'd0, at_target}, 32'hF);
        chk("rst_nextangle", {31'd0, nextangle}, 32'd0);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_frame_tick", {31'd0, frame_tick}, 32'd0);

        reset = 1'b0;
        wait_load(m);
        chk("first_load_cycle", 1 + m, 25);
        chk("first_load_angles", {angle1, angle2, angle3, angle4}, {8'd90, 8'd90, 8'd90, 8'd90});

        // Channel 0 ramps 90 -> 100 in steps of 2.
        step();
        chk("idle_ready", {31'd0, cmd_ready}, 32'd1);
        send(2'd0, 8'd100);
        chk("ch0_at_target", {28'd0, at_target}, 32'b1110);
        for (int k = 1; k <= 5; k++) begin
            wait_load(m);
            chk("ch0_ramp", {24'd0, angle1}, 32'(90 + 2 * k));
            chk("ch0_others", {angle2, angle3, angle4}, {8'd90, 8'd90, 8'd90});
        end
        chk("ch0_settled", {28'd0, at_target}, 32'hF);

        // Channel 3 to 89: within one step, no overshoot.
        step();
        send(2'd3, 8'd89);
        chk("ch3_at_target", {28'd0, at_target}, 32'b0111);
        wait_load(m);
        chk("ch3_angle", {24'd0, angle4}, 32'd89);
        chk("ch3_settled", {28'd0, at_target}, 32'hF);

        // Channel 1 to 250 clamps at 180.
        step();
        send(2'd1, 8'd250);
        chk("ch1_at_target", {28'd0, at_target}, 32'b1101);
        for (int k = 1; k <= 45; k++) begin
            wait_load(m);
            chk("ch1_ramp", {24'd0, angle2}, 32'(90 + 2 * k));
        end
        chk("ch1_settled", {28'd0, at_target}, 32'hF);
        wait_load(m);
        chk("ch1_hold_180", {24'd0, angle2}, 32'd180);

        // Held cmd_valid across a frame boundary; value changes on the tick cycle.
        step();
        cmd_valid = 1'b1;
        cmd_chan  = 2'd2;
        cmd_angle = 8'd80;
        repeat (14) step();
        chk("tick_cycle_ready", {31'd0, cmd_ready}, 32'd1);
        cmd_angle = 8'd89;
        step();
        chk("frame_tick_pulse", {31'd0, frame_tick}, 32'd1);
        zeros    = 0;
        load_idx = -1;
        for (int k = 0; k < 6; k++) begin
            if (cmd_ready === 1'b0) zeros++;
            if (nextangle === 1'b1) begin
                load_idx = k;
                chk("tick_cmd_angle3", {24'd0, angle3}, 32'd89);
            end
            if (k < 5) step();
        end
        chk("ready_low_cycles", zeros, 5);
        chk("load_index", load_idx, 4);
        chk("ready_back", {31'd0, cmd_ready}, 32'd1);

        // Target ch2 to 0, then reset during UPD2.
        cmd_angle = 8'd0;
        step();
        cmd_valid = 1'b0;
        chk("ch2_at_target", {28'd0, at_target}, 32'b1011);
        repeat (13) step();
        step();
        step();
        step();
        reset = 1'b1;
        step();
        chk("midrst_angles", {angle1, angle2, angle3, angle4}, {8'd90, 8'd90, 8'd90, 8'd90});
        chk("midrst_at_target", {28'd0, at_target}, 32'hF);
        chk("midrst_nextangle", {31'd0, nextangle}, 32'd0);
        chk("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        reset = 1'b0;
        wait_load(m);
        chk("post_rst_load_cycle", 1 + m, 25);
        chk("post_rst_angles", {angle1, angle2, angle3, angle4}, {8'd90, 8'd90, 8'd90, 8'd90});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/servo_angle_sequencer.md
Name: servo_angle_sequencer

Overview:
- Frame-synchronous controller for the 4-channel servo PWM generator.
- Accepts per-channel target angles over a valid/ready command port.
- Once per PWM frame, slews each channel's current angle toward its target by at most STEP degrees.
- Presents the result on angle1..angle4 with a one-cycle nextangle load strobe, so the PWM block only reloads at frame boundaries and servos never see step jumps.

Parameters:
- FRAME_CYCLES, 1000000, clk cycles per PWM frame (20 ms at 50 MHz); must be >= 8.
- STEP, 2, max degrees moved per channel per frame; range 1..180.
- MAX_ANGLE, 180, upper clamp for targets, in degrees.
- HOME_ANGLE, 90, reset value of targets and current angles; must be <= MAX_ANGLE.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command can be accepted this cycle.
- cmd_chan  in  2  target channel, 0..3 maps to angle1..angle4.
- cmd_angle  in  8  requested target angle in degrees.
- angle1  out  8  current angle, channel 0.
- angle2  out  8  current angle, channel 1.
- angle3  out  8  current angle, channel 2.
- angle4  out  8  current angle, channel 3.
- nextangle  out  1  one-cycle load strobe to the PWM block.
- at_target  out  4  bit i high when channel i's current angle equals its target.
- frame_tick  out  1  one-cycle pulse when the frame counter wraps (debug/sync).

Behaviour:
- Single clock domain: clk. Reset is synchronous, active-high.
- Reset values:
  - fcnt = 0; state = IDLE; cmd_ready = 0 during reset.
  - All targets and current angles = HOME_ANGLE; angle1..4 = HOME_ANGLE.
  - nextangle = 0; frame_tick = 0; at_target = 4'hF.
- Frame counter fcnt runs 0..FRAME_CYCLES-1 and wraps to 0. It runs freely in every state.
- The tick condition is fcnt == FRAME_CYCLES-1. frame_tick is registered, so it is high on the cycle after that condition.
- State machine:
  - IDLE: cmd_ready = 1. On the tick condition, go to UPD0.
  - UPD0..UPD3: one channel per cycle, in channel order 0..3. cmd_ready = 0. UPD3 goes to LOAD.
  - LOAD: angle1..4 registered from the current-angle registers; nextangle = 1 for exactly this cycle; cmd_ready = 0. Next state is IDLE.
- Latency: tick condition at cycle T gives UPD0..UPD3 at T+1..T+4 and nextangle = 1 at T+5. angle1..4 change on the same edge that raises nextangle and are stable for the whole frame.
- Command accept is cmd_valid && cmd_ready.
  - The target register for cmd_chan is written next edge with min(cmd_angle, MAX_ANGLE).
  - Targets are never written outside IDLE.
- Command accepted in the same cycle as the tick condition: the new target is used by the UPDn that follows.
- Slew rule per channel in its UPDn cycle, with d = |target - cur| computed at 9-bit width (no wrap):
  - d == 0: cur unchanged.
  - d <= STEP: cur = target.
  - otherwise cur moves by STEP toward target.
  - cur never leaves 0..MAX_ANGLE.
- at_target is combinational: cur == target per channel, computed on the current registers.
  - It can be high before the matching value reaches angle1..4 (until the next LOAD).
  - It drops the cycle after an accepted command that differs from cur.
- Repeated commands to the same channel in one IDLE window: the last accepted command wins.
- Reset asserted mid-UPDn or in LOAD:
  - Next cycle: all reset values; no nextangle pulse.
  - The first post-reset LOAD occurs FRAME_CYCLES+5 cycles after reset is released.
- No back-pressure from the PWM block. nextangle is a pulse, not a handshake.

Test Plan:
- Reset with FRAME_CYCLES=20, STEP=2, HOME=90:
  - angle1..4 = 90, at_target = F, nextangle = 0.
  - First nextangle occurs 25 cycles after reset release; angles still 90.
- Command ch0 = 100 accepted in IDLE:
  - at_target = 4'b1110 the next cycle.
  - Successive LOADs give angle1 = 92, 94, 96, 98, 100; after the 100 load, at_target = F.
  - Other channels stay at 90.
- Command ch3 = 89 with STEP=2:
  - One LOAD gives angle4 = 89 (d = 1 <= STEP, no overshoot).
- Command ch1 = 250:
  - Target clamps to 180; angle2 ramps by 2 per frame and settles at 180, never above.
- cmd_valid held across a frame boundary:
  - cmd_ready is 0 for exactly 5 cycles (UPD0..LOAD).
  - A command accepted on the tick-condition cycle is reflected in that same frame's LOAD.
- Reset asserted during UPD2 after ch2 was targeted to 0:
  - No nextangle pulse follows.
  - All outputs return to 90 and at_target = F next cycle.
  - The frame counter restarts from 0.
